serial_rb_loader: RTL

- Parametrised serial-to-register-bank loader, next generation of the 3-bit-address/18-bit-data serial receiver feeding a register bank.
- Deserialises framed (address, data, optional parity) words from a 1-bit serial link gated by active-low sen and issues one write per good frame.
- Adds configurable widths, bit order and even parity; detects aborted frames; tracks per-address coverage so done asserts only when every bank entry has been written.

---
 rtl/serial_rb_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/serial_rb_loader.sv
// Serial-to-register-bank loader: deserialises framed (address, data, parity) words
// from a sen-gated 1-bit link and issues one bank write per good frame.
module serial_rb_loader #(
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              rb_rw,
    output logic [ADDR_W-1:0] rb_a,
    output logic [DATA_W-1:0] rb_d,
    output logic              done,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);

    localparam int unsigned FRAME_L = ADDR_W + DATA_W + PARITY_EN;
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_L + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_L - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WRITE,
        WAIT_HI,
        DONE
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic [DEPTH-1:0]  cov_q;
    logic              rb_rw_q;
    logic [ADDR_W-1:0] rb_a_q;
    logic [DATA_W-1:0] rb_d_q;
    logic              done_q;
    logic              frame_err_q;
    logic [7:0]        err_cnt_q;
    logic              good_c;
    logic [7:0]        err_inc_c;

    // Assembly view including the bit sampled on this edge; cnt_q is its frame index.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        par_d  = (cnt_q == '0) ? sd : (par_q ^ sd);
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            if (32'(cnt_q) == ((LSB_FIRST != 0) ? i : (ADDR_W - 1 - i))) begin
                addr_d[i] = sd;
            end
        end
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (32'(cnt_q) == (ADDR_W + ((LSB_FIRST != 0) ? i : (DATA_W - 1 - i)))) begin
                data_d[i] = sd;
            end
        end
    end

    // Running XOR over every frame bit (parity bit included) must come out even.
    assign good_c    = (PARITY_EN == 0) || !par_d;
    assign err_inc_c = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            par_q       <= 1'b0;
            cov_q       <= '0;
            rb_rw_q     <= 1'b1;
            rb_a_q      <= '0;
            rb_d_q      <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            rb_rw_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!sen) begin
                        addr_q  <= addr_d;
                        data_q  <= data_d;
                        par_q   <= par_d;
                        cnt_q   <= CNT_W'(1);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sen) begin
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= err_inc_c;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end else begin
                        addr_q <= addr_d;
                        data_q <= data_d;
                        par_q  <= par_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            // Final bit: the write strobe is registered here so it
                            // occupies exactly the WRITE cycle.
                            cnt_q   <= '0;
                            state_q <= WRITE;
                            if (good_c) begin
                                rb_rw_q <= 1'b0;
                                rb_a_q  <= addr_d;
                                rb_d_q  <= data_d;
                                cov_q   <= cov_q | (DEPTH'(1) << addr_d);
                            end else begin
                                frame_err_q <= 1'b1;
                                err_cnt_q   <= err_inc_c;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (&cov_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (!sen) begin
                        state_q <= WAIT_HI;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT_HI: begin
                    if (sen) begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rb_rw     = rb_rw_q;
    assign rb_a      = rb_a_q;
    assign rb_d      = rb_d_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
